// File: rtl/ctrl_wbit_ser_if.sv
// rtl/ctrl_wbit_ser_if.sv - weight in / serial bit out bundle for ctrl_wbit_ser
interface ctrl_wbit_ser_if #(
  parameter int Pw = 4,
  parameter int NL = 4
);
  logic [NL*Pw-1:0] w_in;
  logic             w_valid;
  logic             w_ready;
  logic             hold;
  logic             abort;
  logic [NL-1:0]    w_bit;
  logic             w_vld;
  logic             w_cnt;
  logic             bit_first;
  logic             bit_last;
  logic             cnt_clear;
  logic             done;

  modport master (
    output w_in, w_valid, hold, abort,
    input  w_ready, w_bit, w_vld, w_cnt, bit_first, bit_last, cnt_clear, done
  );

  modport slave (
    input  w_in, w_valid, hold, abort,
    output w_ready, w_bit, w_vld, w_cnt, bit_first, bit_last, cnt_clear, done
  );
endinterface

// File: rtl/ctrl_wbit_ser.sv
// rtl/ctrl_wbit_ser.sv - LSB-first bit-serial weight feeder for NL parallel SMAC lanes
module ctrl_wbit_ser #(
  parameter int Pw = 4,
  parameter int NL = 4
) (
  input  logic           clk,
  input  logic           rst,
  ctrl_wbit_ser_if.slave bus
);
  localparam int IW = $clog2(Pw);
  localparam logic [IW-1:0] IDX_LAST = IW'(Pw - 1);

  if (Pw < 2 || Pw > 16) begin : g_pw_range
    $error("ctrl_wbit_ser: Pw must be within 2..16");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [NL*Pw-1:0] r_shift, w_shift_nxt, w_shift_adv;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic             r_done, w_done_nxt;
  logic             r_clr, w_clr_nxt;
  logic             w_vld, w_at_last, w_cnt, w_ready, w_accept;
  logic [NL-1:0]    w_lane_bit;

  assign w_vld     = (r_state == SHIFT);
  assign w_at_last = (r_idx == IDX_LAST);
  assign w_cnt     = w_vld & ~bus.hold;
  // Ready in SHIFT only while the sign bit is being consumed: zero-bubble skid.
  assign w_ready   = ~bus.abort & (~w_vld | (w_at_last & ~bus.hold));
  assign w_accept  = bus.w_valid & w_ready;

  always_comb begin
    w_shift_adv = '0;
    w_lane_bit  = '0;
    for (int k = 0; k < NL; k++) begin
      w_shift_adv[k*Pw +: Pw] = {1'b0, r_shift[k*Pw+1 +: Pw-1]};
      w_lane_bit[k]           = w_vld & r_shift[k*Pw];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_clr_nxt   = 1'b0;
    w_done_nxt  = w_cnt & w_at_last & ~bus.abort;
    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_shift_nxt = '0;
      w_idx_nxt   = '0;
      w_clr_nxt   = 1'b1;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_nxt = SHIFT;
            w_shift_nxt = bus.w_in;
            w_idx_nxt   = '0;
          end
        end
        SHIFT: begin
          if (!bus.hold) begin
            if (w_at_last) begin
              w_idx_nxt = '0;
              if (w_accept) begin
                w_shift_nxt = bus.w_in;
              end else begin
                w_state_nxt = IDLE;
                w_shift_nxt = '0;
              end
            end else begin
              w_idx_nxt   = r_idx + IW'(1);
              w_shift_nxt = w_shift_adv;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_clr   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

  assign bus.w_ready   = w_ready;
  assign bus.w_bit     = w_lane_bit;
  assign bus.w_vld     = w_vld;
  assign bus.w_cnt     = w_cnt;
  assign bus.bit_first = w_vld & (r_idx == '0);
  assign bus.bit_last  = w_vld & w_at_last;
  assign bus.cnt_clear = r_clr;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_ctrl_wbit_ser.sv
// tb/tb_ctrl_wbit_ser.sv - directed and random bench for ctrl_wbit_ser
module tb_ctrl_wbit_ser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  ctrl_wbit_ser_if #(.Pw(4), .NL(4)) bus_a ();
  ctrl_wbit_ser_if #(.Pw(2), .NL(4)) bus_b ();

  ctrl_wbit_ser #(.Pw(4), .NL(4)) u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  ctrl_wbit_ser #(.Pw(2), .NL(4)) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  logic [15:0] q_a[$];
  logic [7:0]  q_b[$];
  int last_a = 0, done_a = 0;
  int first_b = 0, last_b = 0, done_b = 0;
  int pos_a = 0, pos_b = 0;
  int val_a[4];
  int val_b[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial-to-parallel model: weighted sum with the sign bit subtracted.
  always @(negedge clk) begin
    logic [15:0]       ew;
    logic signed [3:0] ln;
    if (!rst_a) begin
      if (!bus_a.w_vld) chk("a_wbit_zero_idle", bus_a.w_bit, 0);
      if (bus_a.done) done_a++;
      if (bus_a.w_cnt) begin
        if (bus_a.bit_first) begin
          pos_a = 0;
          for (int k = 0; k < 4; k++) val_a[k] = 0;
        end
        for (int k = 0; k < 4; k++)
          if (bus_a.w_bit[k]) val_a[k] += bus_a.bit_last ? -(1 << pos_a) : (1 << pos_a);
        pos_a++;
        if (bus_a.bit_last) begin
          last_a++;
          if (q_a.size() == 0) chk("a_sb_underflow", 1, 0);
          else begin
            ew = q_a.pop_front();
            for (int k = 0; k < 4; k++) begin
              ln = ew[k*4 +: 4];
              chk("a_lane_value", val_a[k], int'(ln));
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0]        ew;
    logic signed [1:0] ln;
    if (!rst_b) begin
      if (!bus_b.w_vld) chk("b_wbit_zero_idle", bus_b.w_bit, 0);
      if (bus_b.done) done_b++;
      if (bus_b.w_cnt) begin
        if (bus_b.bit_first) begin
          first_b++;
          pos_b = 0;
          for (int k = 0; k < 4; k++) val_b[k] = 0;
        end
        for (int k = 0; k < 4; k++)
          if (bus_b.w_bit[k]) val_b[k] += bus_b.bit_last ? -(1 << pos_b) : (1 << pos_b);
        pos_b++;
        if (bus_b.bit_last) begin
          last_b++;
          if (q_b.size() == 0) chk("b_sb_underflow", 1, 0);
          else begin
            ew = q_b.pop_front();
            for (int k = 0; k < 4; k++) begin
              ln = ew[k*2 +: 2];
              chk("b_lane_value", val_b[k], int'(ln));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic       acc;
    int         n;
    int         guard;

    bus_a.w_in = '0; bus_a.w_valid = 0; bus_a.hold = 0; bus_a.abort = 0;
    bus_b.w_in = '0; bus_b.w_valid = 0; bus_b.hold = 0; bus_b.abort = 0;
    rst_a = 1; rst_b = 1;

    tick();
    @(negedge clk);
    chk("rst_vld", bus_a.w_vld, 0);
    chk("rst_bit", bus_a.w_bit, 0);
    chk("rst_first", bus_a.bit_first, 0);
    chk("rst_last", bus_a.bit_last, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_clr", bus_a.cnt_clear, 1);
    chk("rst_clr_b", bus_b.cnt_clear, 1);
    rst_a = 0; rst_b = 0;
    tick();
    @(negedge clk);
    chk("exit_clr", bus_a.cnt_clear, 0);
    chk("exit_ready", bus_a.w_ready, 1);

    // single word, lane0 = 0110
    tick();
    bus_a.w_in = 16'h0006; bus_a.w_valid = 1; q_a.push_back(16'h0006);
    @(negedge clk);
    chk("sw_ready", bus_a.w_ready, 1);
    tick();
    bus_a.w_valid = 0;
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sw_bit", bus_a.w_bit[0], pat[i]);
      chk("sw_first", bus_a.bit_first, i == 0);
      chk("sw_last", bus_a.bit_last, i == 3);
      chk("sw_cnt", bus_a.w_cnt, 1);
      tick();
    end
    @(negedge clk);
    chk("sw_done", bus_a.done, 1);
    chk("sw_vld_end", bus_a.w_vld, 0);
    tick();
    @(negedge clk);
    chk("sw_done_once", bus_a.done, 0);

    // back-to-back A=F then B=1
    tick();
    bus_a.w_in = 16'h000F; bus_a.w_valid = 1; q_a.push_back(16'h000F);
    tick();
    bus_a.w_in = 16'h0001; q_a.push_back(16'h0001);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_not_ready", bus_a.w_ready, 0);
      tick();
    end
    @(negedge clk);
    chk("b2b_ready_t4", bus_a.w_ready, 1);
    chk("b2b_last_t4", bus_a.bit_last, 1);
    tick();
    bus_a.w_valid = 0;
    @(negedge clk);
    chk("b2b_done_t5", bus_a.done, 1);
    chk("b2b_vld_t5", bus_a.w_vld, 1);
    chk("b2b_first_t5", bus_a.bit_first, 1);
    chk("b2b_bit_t5", bus_a.w_bit[0], 1);
    chk("b2b_clr_t5", bus_a.cnt_clear, 0);
    tick();
    for (int i = 6; i < 9; i++) begin
      @(negedge clk);
      chk("b2b_no_done", bus_a.done, 0);
      tick();
    end
    @(negedge clk);
    chk("b2b_done_t9", bus_a.done, 1);
    chk("b2b_vld_t9", bus_a.w_vld, 0);
    tick();

    // stall on word 1010
    tick();
    bus_a.w_in = 16'h000A; bus_a.w_valid = 1; q_a.push_back(16'h000A);
    tick();
    bus_a.w_valid = 0;
    @(negedge clk);
    chk("st_bit_t1", bus_a.w_bit[0], 0);
    tick();
    bus_a.hold = 1;
    @(negedge clk);
    chk("st_bit_t2", bus_a.w_bit[0], 1);
    chk("st_cnt_t2", bus_a.w_cnt, 0);
    tick();
    @(negedge clk);
    chk("st_bit_t3", bus_a.w_bit[0], 1);
    chk("st_cnt_t3", bus_a.w_cnt, 0);
    chk("st_first_t3", bus_a.bit_first, 0);
    tick();
    bus_a.hold = 0;
    @(negedge clk);
    chk("st_bit_t4", bus_a.w_bit[0], 1);
    chk("st_cnt_t4", bus_a.w_cnt, 1);
    chk("st_last_t4", bus_a.bit_last, 0);
    tick();
    @(negedge clk);
    chk("st_last_t5", bus_a.bit_last, 0);
    chk("st_bit_t5", bus_a.w_bit[0], 0);
    tick();
    @(negedge clk);
    chk("st_last_t6", bus_a.bit_last, 1);
    chk("st_bit_t6", bus_a.w_bit[0], 1);
    tick();
    @(negedge clk);
    chk("st_done_t7", bus_a.done, 1);
    tick();

    // abort mid-word with a new word presented
    tick();
    bus_a.w_in = 16'h5555; bus_a.w_valid = 1;
    tick();
    bus_a.w_valid = 0;
    tick();
    bus_a.abort = 1; bus_a.w_valid = 1; bus_a.w_in = 16'h3333;
    @(negedge clk);
    chk("ab_ready_t2", bus_a.w_ready, 0);
    tick();
    bus_a.abort = 0; bus_a.w_valid = 0;
    @(negedge clk);
    chk("ab_vld_t3", bus_a.w_vld, 0);
    chk("ab_clr_t3", bus_a.cnt_clear, 1);
    chk("ab_ready_t3", bus_a.w_ready, 1);
    chk("ab_done_t3", bus_a.done, 0);
    tick();
    @(negedge clk);
    chk("ab_clr_t4", bus_a.cnt_clear, 0);
    chk("ab_done_t4", bus_a.done, 0);
    tick();

    // reset mid-word, then a fresh word
    tick();
    bus_a.w_in = 16'hA5C3; bus_a.w_valid = 1;
    tick();
    bus_a.w_valid = 0;
    tick();
    rst_a = 1;
    tick();
    rst_a = 0;
    @(negedge clk);
    chk("rs_vld", bus_a.w_vld, 0);
    chk("rs_bit", bus_a.w_bit, 0);
    chk("rs_first", bus_a.bit_first, 0);
    chk("rs_last", bus_a.bit_last, 0);
    chk("rs_cnt", bus_a.w_cnt, 0);
    chk("rs_done", bus_a.done, 0);
    chk("rs_clr", bus_a.cnt_clear, 1);
    tick();
    bus_a.w_in = 16'h9C63; bus_a.w_valid = 1; q_a.push_back(16'h9C63);
    @(negedge clk);
    chk("rs_clr_t4", bus_a.cnt_clear, 0);
    chk("rs_ready_t4", bus_a.w_ready, 1);
    tick();
    bus_a.w_valid = 0;
    @(negedge clk);
    chk("rs_first_t5", bus_a.bit_first, 1);
    chk("rs_bits_t5", bus_a.w_bit, 4'b1001);
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("rs_done_t9", bus_a.done, 1);
    tick(); tick();
    chk("a_last_count", last_a, 5);
    chk("a_done_count", done_a, 5);
    chk("a_queue_empty", q_a.size(), 0);

    // Pw=2, 8 random words with random hold
    n = 0; guard = 0;
    bus_b.w_valid = 1; bus_b.w_in = 8'($urandom);
    while (n < 8 && guard < 400) begin
      bus_b.hold = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus_b.w_valid && bus_b.w_ready;
      if (acc) begin
        q_b.push_back(bus_b.w_in);
        n++;
      end
      tick();
      guard++;
      if (acc) begin
        bus_b.w_in = 8'($urandom);
        bus_b.w_valid = (n < 8);
      end
    end
    chk("b_accept_timeout", n, 8);
    bus_b.w_valid = 0;
    guard = 0;
    while (done_b < 8 && guard < 200) begin
      bus_b.hold = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    bus_b.hold = 0;
    tick(); tick();
    chk("b_done_count", done_b, 8);
    chk("b_first_count", first_b, 8);
    chk("b_last_count", last_b, 8);
    chk("b_queue_empty", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
